// File: rtl/alarm_pkg.sv
// Shared encodings, BCD limits and wrap-around step helpers for the alarm editor.
// Purely combinational content; no latency of its own.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [3:0] HOUR_MAX_H = 4'd2;
    localparam logic [3:0] HOUR_MAX_L = 4'd3;
    localparam logic [3:0] MIN_MAX_H  = 4'd5;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // Two-digit BCD increment that wraps {max_h,max_l} back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [3:0] max_h,
                                           input logic [3:0] max_l);
        logic [7:0] r;
        if (v[7:4] == max_h && v[3:0] == max_l)
            r = 8'h00;
        else if (v[3:0] == BCD_MAX)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [3:0] max_h,
                                           input logic [3:0] max_l);
        logic [7:0] r;
        if (v == 8'h00)
            r = {max_h, max_l};
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, BCD_MAX};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/alarm_set_key_repeat.sv
// Press-edge plus hold/auto-repeat step generator for one debounced key.
// step is combinational from key and its history, so the consumer's register sees it on the first edge.
module key_repeat #(
    parameter int HOLD_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic enable,
    input  logic repeat_en,
    output logic step
);
    import alarm_pkg::*;

    logic             r_prev;
    logic             r_rep;
    logic [CNT_W-1:0] r_cnt;
    logic             w_press;
    logic             w_hit;

    assign w_press = key & ~r_prev;
    // r_cnt holds cycles elapsed since the press (or since counting resumed).
    assign w_hit   = key & enable &
                     (r_rep ? (r_cnt == CNT_W'(REPEAT_PERIOD)) : (r_cnt == CNT_W'(HOLD_DELAY)));
    assign step    = w_press | (w_hit & repeat_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= key;
            if (!key || !enable) begin
                r_rep <= 1'b0;
                r_cnt <= '0;
            end else if (w_hit) begin
                r_rep <= 1'b1;
                r_cnt <= CNT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_set.sv
// Key-driven alarm time editor: mode FSM, BCD hour/minute stepping, alarm enable toggle.
// All outputs registered; a key press shows on the same edge that first samples it.
module alarm_set #(
    parameter int HOLD_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    output logic [3:0] alarm_hour_h,
    output logic [3:0] alarm_hour_l,
    output logic [3:0] alarm_min_h,
    output logic [3:0] alarm_min_l,
    output logic [1:0] set_mode,
    output logic       alarm_en
);
    import alarm_pkg::*;

    state_t     r_state;
    logic       r_live;
    logic       r_mode_prev;
    logic       r_en;
    logic [7:0] r_hour;
    logic [7:0] r_min;

    logic w_both;
    logic w_mode_press;
    logic w_cnt_en;
    logic w_rep_en;
    logic w_up_raw;
    logic w_dn_raw;
    logic w_up;
    logic w_dn;

    // r_live masks the first edge after reset so keys held through reset are not seen as presses.
    assign w_both       = key_up & key_down;
    assign w_mode_press = key_mode & ~r_mode_prev & r_live;
    assign w_cnt_en     = r_live & ~w_both & ~w_mode_press;
    assign w_rep_en     = (r_state != ST_IDLE);
    assign w_up         = w_up_raw & r_live & ~w_both;
    assign w_dn         = w_dn_raw & r_live & ~w_both;

    key_repeat #(
        .HOLD_DELAY   (HOLD_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key_up),
        .enable   (w_cnt_en),
        .repeat_en(w_rep_en),
        .step     (w_up_raw)
    );

    key_repeat #(
        .HOLD_DELAY   (HOLD_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_down (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key_down),
        .enable   (w_cnt_en),
        .repeat_en(w_rep_en),
        .step     (w_dn_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_mode_prev <= 1'b0;
            r_en        <= 1'b0;
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
        end else begin
            r_live      <= 1'b1;
            r_mode_prev <= key_mode;
            // The step acts on the current state even when mode advances this same edge.
            if (w_up || w_dn) begin
                case (r_state)
                    ST_IDLE:     r_en   <= ~r_en;
                    ST_SET_HOUR: r_hour <= w_up ? bcd_inc(r_hour, HOUR_MAX_H, HOUR_MAX_L)
                                                : bcd_dec(r_hour, HOUR_MAX_H, HOUR_MAX_L);
                    ST_SET_MIN:  r_min  <= w_up ? bcd_inc(r_min, MIN_MAX_H, BCD_MAX)
                                                : bcd_dec(r_min, MIN_MAX_H, BCD_MAX);
                    default:     r_en   <= r_en;
                endcase
            end
            if (w_mode_press) begin
                case (r_state)
                    ST_IDLE:     r_state <= ST_SET_HOUR;
                    ST_SET_HOUR: r_state <= ST_SET_MIN;
                    default:     r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign alarm_hour_h = r_hour[7:4];
    assign alarm_hour_l = r_hour[3:0];
    assign alarm_min_h  = r_min[7:4];
    assign alarm_min_l  = r_min[3:0];
    assign set_mode     = r_state;
    assign alarm_en     = r_en;

endmodule

// File: tb/tb_alarm_set.sv
// Vector table plus hand sequences for hold/repeat, dual-key and reset-while-held cases.
module tb_alarm_set;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_up;
    logic       key_down;
    logic [3:0] alarm_hour_h;
    logic [3:0] alarm_hour_l;
    logic [3:0] alarm_min_h;
    logic [3:0] alarm_min_l;
    logic [1:0] set_mode;
    logic       alarm_en;

    always #5 clk = ~clk;

    alarm_set #(
        .HOLD_DELAY   (8),
        .REPEAT_PERIOD(3),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode    (key_mode),
        .key_up      (key_up),
        .key_down    (key_down),
        .alarm_hour_h(alarm_hour_h),
        .alarm_hour_l(alarm_hour_l),
        .alarm_min_h (alarm_min_h),
        .alarm_min_l (alarm_min_l),
        .set_mode    (set_mode),
        .alarm_en    (alarm_en)
    );

    typedef struct {
        logic        rst_n;
        logic        m;
        logic        u;
        logic        d;
        logic [15:0] t;
        logic [1:0]  md;
        logic        en;
    } vec_t;

    typedef struct {
        logic [15:0] t;
        logic [1:0]  md;
        logic        en;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   vidx  = 0;

    task automatic v(input logic r, input logic m, input logic u, input logic d,
                     input logic [15:0] t, input logic [1:0] md, input logic en);
        vec_t x;
        x.rst_n = r; x.m = m; x.u = u; x.d = d; x.t = t; x.md = md; x.en = en;
        tbl.push_back(x);
    endtask

    task automatic apply(input vec_t x);
        exp_t e;
        exp_t g;
        logic [15:0] act_t;
        rst_n    = x.rst_n;
        key_mode = x.m;
        key_up   = x.u;
        key_down = x.d;
        e.t = x.t; e.md = x.md; e.en = x.en;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        act_t = {alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l};
        total++;
        if (act_t !== g.t || set_mode !== g.md || alarm_en !== g.en) begin
            bad++;
            $display("FAIL vec%0d: got time=%h mode=%0d en=%b, want time=%h mode=%0d en=%b",
                     vidx, act_t, set_mode, alarm_en, g.t, g.md, g.en);
        end
        vidx++;
    endtask

    task automatic run(input logic r, input logic m, input logic u, input logic d,
                       input logic [15:0] t, input logic [1:0] md, input logic en);
        vec_t x;
        x.rst_n = r; x.m = m; x.u = u; x.d = d; x.t = t; x.md = md; x.en = en;
        apply(x);
    endtask

    initial begin
        int offs[5];
        int n;
        offs = '{0, 8, 11, 14, 17};
        rst_n = 1'b0; key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;

        // Reset, idle, alarm_en toggles in IDLE.
        v(0,0,0,0,16'h0000,0,0); v(0,0,0,0,16'h0000,0,0);
        for (int i = 0; i < 10; i++) v(1,0,0,0,16'h0000,0,0);
        v(1,0,1,0,16'h0000,0,1); v(1,0,0,0,16'h0000,0,1);
        v(1,0,1,0,16'h0000,0,0); v(1,0,0,0,16'h0000,0,0);
        v(1,0,0,1,16'h0000,0,1); v(1,0,0,0,16'h0000,0,1);
        // Two mode presses to SET_MIN; release has no effect.
        v(1,1,0,0,16'h0000,1,1); v(1,0,0,0,16'h0000,1,1);
        v(1,1,0,0,16'h0000,2,1); v(1,0,0,0,16'h0000,2,1);
        // Minute wraps, hours untouched.
        v(1,0,0,1,16'h0059,2,1); v(1,0,0,0,16'h0059,2,1);
        v(1,0,1,0,16'h0000,2,1); v(1,0,0,0,16'h0000,2,1);
        v(1,0,0,1,16'h0059,2,1); v(1,0,0,0,16'h0059,2,1);
        v(1,0,0,1,16'h0058,2,1); v(1,0,0,0,16'h0058,2,1);
        v(1,0,1,0,16'h0059,2,1); v(1,0,0,0,16'h0059,2,1);
        // Mode back to IDLE then SET_HOUR; hour wraps 00<->23.
        v(1,1,0,0,16'h0059,0,1); v(1,0,0,0,16'h0059,0,1);
        v(1,1,0,0,16'h0059,1,1); v(1,0,0,0,16'h0059,1,1);
        v(1,0,0,1,16'h2359,1,1); v(1,0,0,0,16'h2359,1,1);
        v(1,0,1,0,16'h0059,1,1); v(1,0,0,0,16'h0059,1,1);

        foreach (tbl[i]) apply(tbl[i]);

        // Hold up 20 cycles from 00: steps at +0, +8, +11, +14, +17.
        for (int k = 0; k < 20; k++) begin
            n = 0;
            foreach (offs[j]) if (offs[j] <= k) n++;
            run(1,0,1,0,{4'd0, 4'(n), 8'h59},1,1);
        end
        for (int k = 0; k < 10; k++) run(1,0,0,0,16'h0559,1,1);

        // Taps 05 -> 09, then 09 -> 10 and 10 -> 09.
        for (int h = 6; h <= 9; h++) begin
            run(1,0,1,0,{4'd0, 4'(h), 8'h59},1,1);
            run(1,0,0,0,{4'd0, 4'(h), 8'h59},1,1);
        end
        run(1,0,1,0,16'h1059,1,1); run(1,0,0,0,16'h1059,1,1);
        run(1,0,0,1,16'h0959,1,1); run(1,0,0,0,16'h0959,1,1);

        // Mode and up together: step applies in SET_HOUR, then FSM moves to SET_MIN.
        run(1,1,1,0,16'h1059,2,1); run(1,0,0,0,16'h1059,2,1);

        // Both keys held: nothing; drop down, up steps only 8 cycles later.
        for (int k = 0; k < 20; k++) run(1,0,1,1,16'h1059,2,1);
        for (int k = 0; k <= 8; k++) run(1,0,1,0,(k < 8) ? 16'h1059 : 16'h1000,2,1);
        run(1,0,0,0,16'h1000,2,1);

        // Back to SET_HOUR, hold up into repeat, then reset while still held.
        run(1,1,0,0,16'h1000,0,1); run(1,0,0,0,16'h1000,0,1);
        run(1,1,0,0,16'h1000,1,1); run(1,0,0,0,16'h1000,1,1);
        for (int k = 0; k < 10; k++) run(1,0,1,0,(k < 8) ? 16'h1100 : 16'h1200,1,1);
        run(0,0,1,0,16'h0000,0,0);
        for (int k = 0; k < 15; k++) run(1,0,1,0,16'h0000,0,0);
        run(1,0,0,0,16'h0000,0,0);
        run(1,0,1,0,16'h0000,0,1); run(1,0,0,0,16'h0000,0,1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
